// File: rtl/pu_drain_pkg.sv
// Shared definitions for the PU drain stage.
// Holds the drain FSM state type, the default lane/sample widths shared with the
// MAC processing unit, and the signed saturation limits of a requantized sample.
package pu_drain_pkg;

    localparam int unsigned OUTPUT_WIDTH = 32;
    localparam int unsigned MAC_NUM      = 8;
    localparam int unsigned QOUT_WIDTH   = 8;
    localparam int unsigned SHIFT_WIDTH  = 5;

    // Saturation limits for the default QOUT_WIDTH.
    localparam int QOUT_MAX = (1 << (QOUT_WIDTH - 1)) - 1;
    localparam int QOUT_MIN = -(1 << (QOUT_WIDTH - 1));

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } drain_state_e;

endpackage

// File: rtl/pu_drain_if.sv
// Output stream of the drain stage toward the output buffer.
//   data  : signed requantized sample
//   idx   : lane index of data
//   last  : data is the final lane of the pass
//   valid : data/idx/last valid
//   ready : sink accepts when valid && ready
// master = producer (drain stage), slave = consumer (output buffer).
interface pu_drain_if #(
    parameter int unsigned QOUT_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 3
);
    logic signed [QOUT_WIDTH-1:0] data;
    logic [IDX_WIDTH-1:0]         idx;
    logic                         last;
    logic                         valid;
    logic                         ready;

    modport master (output data, output idx, output last, output valid, input ready);
    modport slave  (input data, input idx, input last, input valid, output ready);
endinterface

// File: rtl/pu_drain_requant_sat.sv
// Combinational requantizer for one accumulator lane.
//   acc_i   : signed accumulator
//   shift_i : right-shift amount (0 = pass through)
//   q_o     : rounded, arithmetically shifted, signed-saturated sample
module pu_drain_requant_sat
    import pu_drain_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = OUTPUT_WIDTH,
    parameter int unsigned OUT_WIDTH   = QOUT_WIDTH,
    parameter int unsigned SHIFT_BITS  = SHIFT_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  acc_i,
    input  logic [SHIFT_BITS-1:0]       shift_i,
    output logic signed [OUT_WIDTH-1:0] q_o
);

    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        (IN_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = (IN_WIDTH + 1)'(-SAT_MAX - 1);

    // One extra bit of headroom so adding the rounding half cannot wrap.
    logic signed [IN_WIDTH:0] acc_ext;
    logic signed [IN_WIDTH:0] half;
    logic signed [IN_WIDTH:0] rounded;
    logic signed [IN_WIDTH:0] shifted;

    always_comb begin
        acc_ext = {acc_i[IN_WIDTH-1], acc_i};
        half    = '0;
        rounded = acc_ext;
        shifted = acc_ext;
        if (shift_i != '0) begin
            half    = (IN_WIDTH + 1)'(1) << (shift_i - SHIFT_BITS'(1));
            rounded = acc_ext + half;
            shifted = rounded >>> shift_i;
        end

        if (shifted > SAT_MAX) begin
            q_o = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            q_o = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            q_o = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pu_drain.sv
// PU drain stage: snapshots all MAC lanes at the end of an accumulation pass,
// pulses a clear back to the PU, then streams requantized lanes one per handshake.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   acc_i         : packed signed accumulators, lane k at [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   acc_valid_i   : one-cycle pulse, acc_i holds final pass results
//   shift_i       : requant right shift, sampled with acc_valid_i
//   acc_ready_o   : snapshot can be accepted (idle)
//   pu_clear_o    : one-cycle clear pulse to the PU after a snapshot
//   drop_o        : sticky, a snapshot request arrived while busy
//   out_if        : requantized sample stream (master)
module pu_drain
    import pu_drain_pkg::*;
#(
    parameter int unsigned OUTPUT_WIDTH = pu_drain_pkg::OUTPUT_WIDTH,
    parameter int unsigned MAC_NUM      = pu_drain_pkg::MAC_NUM,
    parameter int unsigned QOUT_WIDTH   = pu_drain_pkg::QOUT_WIDTH,
    parameter int unsigned SHIFT_WIDTH  = pu_drain_pkg::SHIFT_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [OUTPUT_WIDTH*MAC_NUM-1:0] acc_i,
    input  logic                            acc_valid_i,
    input  logic [SHIFT_WIDTH-1:0]          shift_i,
    output logic                            acc_ready_o,
    output logic                            pu_clear_o,
    output logic                            drop_o,
    pu_drain_if.master                      out_if
);

    localparam int unsigned IDX_WIDTH = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;

    drain_state_e                         state_q, state_d;
    logic [MAC_NUM-1:0][OUTPUT_WIDTH-1:0] snap_q, snap_d;
    logic [SHIFT_WIDTH-1:0]               shift_q, shift_d;
    logic [IDX_WIDTH-1:0]                 cnt_q, cnt_d;
    logic signed [QOUT_WIDTH-1:0]         data_q, data_d;
    logic [IDX_WIDTH-1:0]                 idx_q, idx_d;
    logic                                 last_q, last_d;
    logic                                 valid_q, valid_d;
    logic                                 clear_q, clear_d;
    logic                                 drop_q, drop_d;

    logic signed [QOUT_WIDTH-1:0]         lane_req;

    // Requant of the lane selected by cnt_q feeds the output register directly.
    pu_drain_requant_sat #(
        .IN_WIDTH   (OUTPUT_WIDTH),
        .OUT_WIDTH  (QOUT_WIDTH),
        .SHIFT_BITS (SHIFT_WIDTH)
    ) u_requant (
        .acc_i   (snap_q[cnt_q]),
        .shift_i (shift_q),
        .q_o     (lane_req)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        clear_d = 1'b0;
        drop_d  = drop_q;

        unique case (state_q)
            StIdle: begin
                if (acc_valid_i) begin
                    snap_d  = acc_i;
                    shift_d = shift_i;
                    cnt_d   = '0;
                    clear_d = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (acc_valid_i) begin
                    drop_d = 1'b1;
                end
                // Output register is empty or being emptied this cycle.
                if (!valid_q || out_if.ready) begin
                    if (valid_q && last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        data_d  = lane_req;
                        idx_d   = cnt_q;
                        last_d  = (cnt_q == IDX_WIDTH'(MAC_NUM - 1));
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            snap_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            clear_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            clear_q <= clear_d;
            drop_q  <= drop_d;
        end
    end

    assign acc_ready_o  = (state_q == StIdle);
    assign pu_clear_o   = clear_q;
    assign drop_o       = drop_q;
    assign out_if.data  = data_q;
    assign out_if.idx   = idx_q;
    assign out_if.last  = last_q;
    assign out_if.valid = valid_q;

endmodule

// File: tb/tb_pu_drain.sv
module tb_pu_drain;
    import pu_drain_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] acc;
    logic         acc_valid;
    logic [4:0]   shift;
    logic         acc_ready;
    logic         pu_clear;
    logic         drop;
    logic         rdy;

    pu_drain_if #(.QOUT_WIDTH(8), .IDX_WIDTH(3)) out_if ();
    assign out_if.ready = rdy;

    pu_drain dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .acc_i       (acc),
        .acc_valid_i (acc_valid),
        .shift_i     (shift),
        .acc_ready_o (acc_ready),
        .pu_clear_o  (pu_clear),
        .drop_o      (drop),
        .out_if      (out_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int lane_v [8];
    int cur_shift;

    int got_n, first_valid_iter, clear_cnt, clear_iter, stable_err;
    int got_data [16];
    int got_idx  [16];
    int got_last [16];
    int hs_iter  [16];
    int post_valid, post_acc_ready;

    // Reference: round-half-up arithmetic shift in wide arithmetic, then clamp.
    function automatic int ref_requant(input int a, input int s);
        longint r;
        if (s == 0) r = a;
        else        r = (longint'(a) + (longint'(1) << (s - 1))) >>> s;
        if (r > QOUT_MAX) r = QOUT_MAX;
        if (r < QOUT_MIN) r = QOUT_MIN;
        return int'(r);
    endfunction

    // Called at a negedge; presents the snapshot for one edge, then the PU clears acc.
    task automatic capture(input int s);
        for (int k = 0; k < 8; k++) acc[k*32 +: 32] = lane_v[k];
        shift     = 5'(s);
        cur_shift = s;
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        acc       = '0;
    endtask

    // Runs the drain from the negedge after capture until the last handshake.
    // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_drain(input int mode, input int drop_iter, input bit drop_on_last);
        int  pv, pr, pd, pi, pl;
        bit  done;
        pv = 0; pr = 1; pd = 0; pi = 0; pl = 0; done = 0;
        got_n = 0; first_valid_iter = -1; clear_cnt = 0; clear_iter = -1; stable_err = 0;
        for (int it = 0; it < 200 && !done; it++) begin
            if (pu_clear) begin
                clear_cnt++;
                if (clear_iter < 0) clear_iter = it;
            end
            if (out_if.valid && first_valid_iter < 0) first_valid_iter = it;
            if (pv != 0 && pr == 0) begin
                if (!out_if.valid || int'(out_if.data) != pd || int'(out_if.idx) != pi ||
                    int'(out_if.last) != pl) stable_err++;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (it % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            acc_valid = (it == drop_iter);
            if (out_if.valid && rdy) begin
                if (got_n < 16) begin
                    got_data[got_n] = int'(out_if.data);
                    got_idx[got_n]  = int'(out_if.idx);
                    got_last[got_n] = int'(out_if.last);
                    hs_iter[got_n]  = it;
                end
                got_n++;
                if (out_if.last) begin
                    done = 1;
                    if (drop_on_last) acc_valid = 1'b1;
                end
            end
            if (acc_valid) acc = {8{$urandom}};
            pv = int'(out_if.valid); pr = int'(rdy);
            pd = int'(out_if.data); pi = int'(out_if.idx); pl = int'(out_if.last);
            @(negedge clk);
        end
        acc_valid      = 1'b0;
        rdy            = 1'b1;
        post_valid     = int'(out_if.valid);
        post_acc_ready = int'(acc_ready);
    endtask

    task automatic test_reset();
        rst = 1'b1; acc = '0; acc_valid = 1'b0; shift = '0; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (acc_ready !== 1'b1) begin failures++;
            $display("FAIL reset_acc_ready got=%b want=1", acc_ready); end
        checks++; if (out_if.valid !== 1'b0 || pu_clear !== 1'b0 || drop !== 1'b0) begin
            failures++; $display("FAIL reset_flags valid=%b clear=%b drop=%b want=000",
                                 out_if.valid, pu_clear, drop); end
        checks++; if (out_if.data !== 8'd0 || out_if.idx !== 3'd0 || out_if.last !== 1'b0)
            begin failures++; $display("FAIL reset_data data=%0d idx=%0d last=%b want=0 0 0",
                                       out_if.data, out_if.idx, out_if.last); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int vals [8] = '{100, -100, 3, -3, 1000, -1000, 127, -129};
        int want [8] = '{100, -100, 3, -3, 127, -128, 127, -128};
        lane_v = vals;
        capture(0);
        run_drain(0, -1, 1'b0);
        checks++; if (clear_cnt != 1 || clear_iter != 0) begin failures++;
            $display("FAIL sat_clear count=%0d at=%0d want=1 at 0", clear_cnt, clear_iter); end
        checks++; if (first_valid_iter != 1) begin failures++;
            $display("FAIL sat_latency got=%0d want=1", first_valid_iter); end
        checks++; if (got_n != 8) begin failures++;
            $display("FAIL sat_count got=%0d want=8", got_n); end
        for (int k = 0; k < 8 && k < got_n; k++) begin
            checks++;
            if (got_data[k] != want[k] || got_idx[k] != k || got_last[k] != int'(k == 7) ||
                hs_iter[k] != k + 1) begin
                failures++;
                $display("FAIL sat_lane%0d data=%0d idx=%0d last=%0d it=%0d want %0d %0d %0d %0d",
                         k, got_data[k], got_idx[k], got_last[k], hs_iter[k],
                         want[k], k, int'(k == 7), k + 1);
            end
        end
        checks++; if (post_valid != 0 || post_acc_ready != 1) begin failures++;
            $display("FAIL sat_post valid=%0d ready=%0d want 0 1", post_valid, post_acc_ready); end
    endtask

    task automatic test_rounding();
        int want [5] = '{1, 2, -1, -1, 2};
        lane_v = '{5, 6, -5, -6, 7, int'($urandom), -77, 9};
        capture(2);
        run_drain(0, -1, 1'b0);
        checks++; if (got_n != 8) begin failures++;
            $display("FAIL round_count got=%0d want=8", got_n); end
        for (int k = 0; k < 5 && k < got_n; k++) begin
            checks++; if (got_data[k] != want[k]) begin failures++;
                $display("FAIL round_lane%0d got=%0d want=%0d", k, got_data[k], want[k]); end
        end
        for (int k = 5; k < 8 && k < got_n; k++) begin
            checks++; if (got_data[k] != ref_requant(lane_v[k], 2)) begin failures++;
                $display("FAIL round_lane%0d got=%0d want=%0d", k, got_data[k],
                         ref_requant(lane_v[k], 2)); end
        end
    endtask

    task automatic test_overflow();
        lane_v = '{32'h7FFFFFFF, 32'h80000000, 32'h40000000, -1, 0, 32'h7FFFFFFE, 32'hC0000000,
                   32'hBFFFFFFF};
        capture(31);
        run_drain(0, -1, 1'b0);
        checks++; if (got_n != 8) begin failures++;
            $display("FAIL ovf_count got=%0d want=8", got_n); end
        checks++; if (got_n > 1 && (got_data[0] != 1 || got_data[1] != -1)) begin failures++;
            $display("FAIL ovf_extremes got=%0d,%0d want=1,-1", got_data[0], got_data[1]); end
        for (int k = 2; k < 8 && k < got_n; k++) begin
            checks++; if (got_data[k] != ref_requant(lane_v[k], 31)) begin failures++;
                $display("FAIL ovf_lane%0d got=%0d want=%0d", k, got_data[k],
                         ref_requant(lane_v[k], 31)); end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 8; k++) lane_v[k] = k;
        capture(0);
        run_drain(1, -1, 1'b0);
        checks++; if (got_n != 8) begin failures++;
            $display("FAIL bp_count got=%0d want=8", got_n); end
        checks++; if (stable_err != 0) begin failures++;
            $display("FAIL bp_stable got=%0d unstable stalls want=0", stable_err); end
        for (int k = 0; k < 8 && k < got_n; k++) begin
            checks++; if (got_data[k] != k || got_idx[k] != k) begin failures++;
                $display("FAIL bp_lane%0d data=%0d idx=%0d want=%0d", k, got_data[k],
                         got_idx[k], k); end
        end
    endtask

    task automatic test_drop();
        int s;
        checks++; if (drop !== 1'b0) begin failures++;
            $display("FAIL drop_before got=%b want=0", drop); end
        for (int k = 0; k < 8; k++) lane_v[k] = int'($urandom);
        s = int'($urandom_range(0, 31));
        capture(s);
        run_drain(0, 3, 1'b1);
        checks++; if (clear_cnt != 1 || got_n != 8) begin failures++;
            $display("FAIL drop_clear clears=%0d lanes=%0d want=1 8", clear_cnt, got_n); end
        for (int k = 0; k < 8 && k < got_n; k++) begin
            checks++; if (got_data[k] != ref_requant(lane_v[k], s)) begin failures++;
                $display("FAIL drop_lane%0d got=%0d want=%0d", k, got_data[k],
                         ref_requant(lane_v[k], s)); end
        end
        checks++; if (drop !== 1'b1 || post_acc_ready != 1 || post_valid != 0) begin
            failures++; $display("FAIL drop_flag drop=%b ready=%0d valid=%0d want 1 1 0",
                                 drop, post_acc_ready, post_valid); end
        for (int k = 0; k < 8; k++) lane_v[k] = int'($urandom_range(0, 400)) - 200;
        capture(1);
        run_drain(0, -1, 1'b0);
        checks++; if (clear_cnt != 1 || got_n != 8 || drop !== 1'b1) begin failures++;
            $display("FAIL drop_next clears=%0d lanes=%0d drop=%b want 1 8 1",
                     clear_cnt, got_n, drop); end
        for (int k = 0; k < 8 && k < got_n; k++) begin
            checks++; if (got_data[k] != ref_requant(lane_v[k], 1)) begin failures++;
                $display("FAIL drop_next_lane%0d got=%0d want=%0d", k, got_data[k],
                         ref_requant(lane_v[k], 1)); end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit hit;
        hit = 0;
        for (int k = 0; k < 8; k++) lane_v[k] = int'($urandom);
        capture(4);
        rdy = 1'b1;
        for (int it = 0; it < 50 && !hit; it++) begin
            if (out_if.valid && out_if.idx == 3'd3) hit = 1;
            else @(negedge clk);
        end
        checks++; if (!hit) begin failures++;
            $display("FAIL rstmid_reach got=no idx3 want=idx3 seen"); end
        rst = 1'b1;
        #1;
        checks++; if (out_if.valid !== 1'b0 || acc_ready !== 1'b1 || drop !== 1'b0) begin
            failures++; $display("FAIL rstmid_state valid=%b ready=%b drop=%b want 0 1 0",
                                 out_if.valid, acc_ready, drop); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) lane_v[k] = int'($urandom_range(0, 2000)) - 1000;
        capture(3);
        run_drain(0, -1, 1'b0);
        checks++; if (got_n != 8 || got_idx[0] != 0) begin failures++;
            $display("FAIL rstmid_restart lanes=%0d idx0=%0d want 8 0", got_n, got_idx[0]); end
        for (int k = 0; k < 8 && k < got_n; k++) begin
            checks++; if (got_data[k] != ref_requant(lane_v[k], 3) || got_idx[k] != k) begin
                failures++; $display("FAIL rstmid_lane%0d data=%0d idx=%0d want %0d %0d", k,
                                     got_data[k], got_idx[k], ref_requant(lane_v[k], 3), k); end
        end
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 1) == 0) lane_v[k] = int'($urandom);
                else lane_v[k] = int'($urandom_range(0, 1200)) - 600;
            end
            s = int'($urandom_range(0, 31));
            capture(s);
            run_drain(2, -1, 1'b0);
            checks++; if (got_n != 8 || stable_err != 0) begin failures++;
                $display("FAIL rand%0d_count lanes=%0d unstable=%0d want 8 0", n, got_n,
                         stable_err); end
            for (int k = 0; k < 8 && k < got_n; k++) begin
                checks++;
                if (got_data[k] != ref_requant(lane_v[k], s) || got_idx[k] != k) begin
                    failures++;
                    $display("FAIL rand%0d_lane%0d data=%0d idx=%0d want %0d %0d (acc=%0d s=%0d)",
                             n, k, got_data[k], got_idx[k], ref_requant(lane_v[k], s), k,
                             lane_v[k], s);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_rounding();
        test_overflow();
        test_backpressure();
        test_drop();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
